// File: rtl/uart_tx_fsm_if.sv
// UART transmitter request/line bundle.
// Master drives the word and request; slave drives the line.
interface uart_tx_fsm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) ();
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  parity_enable;
  logic                  parity_type;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, parity_enable,
    output parity_type, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, parity_enable,
    input  parity_type, Prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, data LSB first,
// optional parity, one stop bit; P cycles per bit.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fsm_if.slave   bus
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pe_q, pe_d;
  logic                  pt_q, pt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  last;
  logic [PRESCALE_W-1:0] p_eff;

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

  // State, counters, shadow regs and registered line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      pt_q    <= 1'b0;
      presc_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      pt_q    <= pt_d;
      presc_q <= presc_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, then line value for that state.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pe_d    = pe_q;
    pt_d    = pt_q;
    presc_d = presc_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    p_eff   = (bus.Prescale == '0) ?
              PRESCALE_W'(1) : bus.Prescale;
    last    = (edge_q == presc_q - PRESCALE_W'(1));

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (bus.Data_Valid) begin
          data_d  = bus.P_DATA;
          pe_d    = bus.parity_enable;
          pt_d    = bus.parity_type;
          presc_d = p_eff;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          edge_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          edge_d = edge_q + PRESCALE_W'(1);
        end
      end
      DATA: begin
        if (last) begin
          edge_d = '0;
          if (bit_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = pe_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end else begin
          edge_d = edge_q + PRESCALE_W'(1);
        end
      end
      PARITY: begin
        if (last) begin
          edge_d  = '0;
          state_d = STOP;
        end else begin
          edge_d = edge_q + PRESCALE_W'(1);
        end
      end
      STOP: begin
        if (last) begin
          edge_d  = '0;
          bit_d   = '0;
          state_d = IDLE;
        end else begin
          edge_d = edge_q + PRESCALE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase

    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = data_d[bit_d[IDX_W-1:0]];
      PARITY: tx_d = pt_d ? ~^data_d : ^data_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed self-checking bench for uart_tx_fsm.
// Per-task inline checks of captured line/busy.
module tb_uart_tx_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  logic [0:255] got_tx, got_bz;
  logic [0:255] exp_tx, exp_bz;

  uart_tx_fsm_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

  uart_tx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Per-cycle expansion of a bit sequence, padded after.
  function automatic logic [0:255] expand(
    input logic [0:31] seq, input int nbits,
    input int p, input int ncyc, input logic pad);
    logic [0:255] r;
    r = '0;
    for (int c = 0; c < ncyc; c++)
      r[c] = (c < nbits * p) ? seq[c / p] : pad;
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input logic pe,
                      input logic pt, input logic [5:0] p);
    @(negedge clk);
    bus.P_DATA = d;
    bus.parity_enable = pe;
    bus.parity_type = pt;
    bus.Prescale = p;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.Data_Valid = 1'b0;
  endtask

  task automatic capture(input int ncyc);
    got_tx = '0;
    got_bz = '0;
    for (int i = 0; i < ncyc; i++) begin
      got_tx[i] = bus.TX_OUT;
      got_bz[i] = bus.busy;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #12;
    n_tot++;
    if (bus.TX_OUT !== 1'b1)
      $display("FAIL rst_tx got=%b exp=1", bus.TX_OUT);
    else n_pass++;
    n_tot++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_busy got=%b exp=0", bus.busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL idle_after_rst got=%b%b exp=10",
               bus.TX_OUT, bus.busy);
    else n_pass++;
  endtask

  task automatic test_even_p1;
    int cnt;
    send(8'hA5, 1'b1, 1'b0, 6'd1);
    capture(14);
    exp_tx = expand(32'b01010010101 << 21, 11, 1, 14, 1'b1);
    exp_bz = expand(32'hFFFF_FFFF, 11, 1, 14, 1'b0);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL even_p1_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    n_tot++;
    if (got_bz !== exp_bz)
      $display("FAIL even_p1_busy got=%h exp=%h", got_bz, exp_bz);
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 256; i++) cnt += int'(got_bz[i]);
    n_tot++;
    if (cnt !== 11)
      $display("FAIL even_p1_len got=%0d exp=11", cnt);
    else n_pass++;
  endtask

  task automatic test_no_parity_p8;
    int cnt;
    send(8'h0F, 1'b0, 1'b0, 6'd8);
    capture(84);
    exp_tx = expand(32'b0111100001 << 22, 10, 8, 84, 1'b1);
    exp_bz = expand(32'hFFFF_FFFF, 10, 8, 84, 1'b0);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL nopar_p8_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    n_tot++;
    if (got_bz !== exp_bz)
      $display("FAIL nopar_p8_busy got=%h exp=%h", got_bz, exp_bz);
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 256; i++) cnt += int'(got_bz[i]);
    n_tot++;
    if (cnt !== 80)
      $display("FAIL nopar_p8_len got=%0d exp=80", cnt);
    else n_pass++;
  endtask

  task automatic test_odd_p4;
    send(8'h01, 1'b1, 1'b1, 6'd4);
    capture(48);
    exp_tx = expand(32'b01000000001 << 21, 11, 4, 48, 1'b1);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL odd_01_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    send(8'h03, 1'b1, 1'b1, 6'd4);
    capture(48);
    exp_tx = expand(32'b01100000011 << 21, 11, 4, 48, 1'b1);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL odd_03_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    exp_bz = expand(32'hFFFF_FFFF, 11, 4, 48, 1'b0);
    n_tot++;
    if (got_bz !== exp_bz)
      $display("FAIL odd_03_busy got=%h exp=%h", got_bz, exp_bz);
    else n_pass++;
  endtask

  task automatic test_ignored;
    send(8'h55, 1'b0, 1'b0, 6'd2);
    got_tx = '0;
    got_bz = '0;
    for (int i = 0; i < 34; i++) begin
      if (i == 6) begin
        bus.P_DATA = 8'hFF;
        bus.Data_Valid = 1'b1;
      end
      if (i == 7) bus.Data_Valid = 1'b0;
      if (i == 9) begin
        bus.Prescale = 6'd5;
        bus.P_DATA = 8'h00;
        bus.parity_enable = 1'b1;
      end
      got_tx[i] = bus.TX_OUT;
      got_bz[i] = bus.busy;
      @(posedge clk);
      #1;
    end
    exp_tx = expand(32'b0101010101 << 22, 10, 2, 34, 1'b1);
    exp_bz = expand(32'hFFFF_FFFF, 10, 2, 34, 1'b0);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL ignore_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    n_tot++;
    if (got_bz !== exp_bz)
      $display("FAIL ignore_busy got=%h exp=%h", got_bz, exp_bz);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    send(8'hA5, 1'b1, 1'b0, 6'd4);
    repeat (20) @(posedge clk);
    #1;
    n_tot++;
    if (bus.TX_OUT !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL pre_rst got=%b%b exp=01",
               bus.TX_OUT, bus.busy);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_tot++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL async_rst got=%b%b exp=10",
               bus.TX_OUT, bus.busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 6'd1);
    capture(13);
    exp_tx = expand(32'b0001111001 << 22, 10, 1, 13, 1'b1);
    exp_bz = expand(32'hFFFF_FFFF, 10, 1, 13, 1'b0);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL post_rst_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    n_tot++;
    if (got_bz !== exp_bz)
      $display("FAIL post_rst_busy got=%h exp=%h", got_bz, exp_bz);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.P_DATA = 8'h3C;
    bus.parity_enable = 1'b0;
    bus.parity_type = 1'b0;
    bus.Prescale = 6'd1;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    capture(21);
    bus.Data_Valid = 1'b0;
    exp_tx = expand(32'b0001111001_1_0001111001 << 11,
                    21, 1, 21, 1'b1);
    exp_bz = expand(32'b1111111111_0_1111111111 << 11,
                    21, 1, 21, 1'b0);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL b2b_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    n_tot++;
    if (got_bz !== exp_bz)
      $display("FAIL b2b_busy got=%h exp=%h", got_bz, exp_bz);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_tot++;
    if (bus.busy !== 1'b0)
      $display("FAIL b2b_stop got=%b exp=0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_prescale0;
    int cnt;
    send(8'hA5, 1'b1, 1'b0, 6'd0);
    capture(14);
    exp_tx = expand(32'b01010010101 << 21, 11, 1, 14, 1'b1);
    n_tot++;
    if (got_tx !== exp_tx)
      $display("FAIL p0_tx got=%h exp=%h", got_tx, exp_tx);
    else n_pass++;
    cnt = 0;
    for (int i = 0; i < 256; i++) cnt += int'(got_bz[i]);
    n_tot++;
    if (cnt !== 11)
      $display("FAIL p0_len got=%0d exp=11", cnt);
    else n_pass++;
  endtask

  initial begin
    bus.P_DATA = '0;
    bus.Data_Valid = 1'b0;
    bus.parity_enable = 1'b0;
    bus.parity_type = 1'b0;
    bus.Prescale = 6'd1;
    test_reset;
    test_even_p1;
    test_no_parity_p8;
    test_odd_p4;
    test_ignored;
    test_reset_mid;
    test_back_to_back;
    test_prescale0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

UART transmitter for the system's UART link: it accepts a parallel word and serializes it onto a single line. Each frame is a start bit, then the data bits LSB first, then an optional parity bit, then one stop bit. Each bit lasts a programmable number of CLK cycles. It sits beside the UART receiver in the UART domain, is fed by the system controller or async FIFO read side, and drives the TX pin.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE_W, 6, width of the Prescale input

Ports:
- CLK  input  1  UART-domain clock; all state on its rising edge
- RST  input  1  asynchronous, active-low reset
- P_DATA  input  DATA_WIDTH  word to transmit
- Data_Valid  input  1  request to send P_DATA; accepted only when busy=0
- parity_enable  input  1  1 = append parity bit
- parity_type  input  1  0 = even, 1 = odd
- Prescale  input  PRESCALE_W  CLK cycles per bit; value 0 is treated as 1
- TX_OUT  output  1  serial line, registered, idles high
- busy  output  1  registered; high while a frame is in flight

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. A clock edge with Data_Valid=1 does the following:
  - latches P_DATA, parity_enable, parity_type and Prescale (after the 0→1 substitution) into shadow registers;
  - computes par_bit = ^data for even parity, ~^data for odd parity;
  - goes to START.
- Inputs are not observed after acceptance. Data_Valid while busy=1 is ignored; no queuing.
- Bit timer edge_cnt counts 0..P-1 (P = latched prescale, width PRESCALE_W). The state or bit advances when edge_cnt==P-1, and edge_cnt wraps to 0 there.
- Bit counter bit_cnt is $clog2(DATA_WIDTH)+1 bits wide and indexes the data bits, 0..DATA_WIDTH-1.
- START: TX_OUT=0 for P cycles, then DATA with bit_cnt=0.
- DATA: TX_OUT=data[bit_cnt] for P cycles per bit. At the end of bit DATA_WIDTH-1, go to PARITY if the latched parity_enable is 1, else STOP.
- PARITY: TX_OUT=par_bit for P cycles, then STOP.
- STOP: TX_OUT=1 for P cycles, then IDLE.
- Counters are cleared on entry to IDLE.
- An illegal state encoding recovers to IDLE with TX_OUT=1 and busy=0.

## Timing
- Reset values: TX_OUT=1, busy=0, state IDLE, all counters 0, shadow registers 0.
- Reset is asynchronous: asserting RST mid-frame forces TX_OUT=1 and busy=0 immediately; the frame is abandoned.
- Outputs are registered. On the accepting edge k, TX_OUT becomes 0 and busy becomes 1 (visible after edge k).
- Frame length N = (2 + DATA_WIDTH + pe) × P cycles, where pe is the latched parity_enable. busy is high for exactly N cycles.
- After the last stop-bit cycle, TX_OUT=1 and busy=0 for at least one cycle before the next frame can start. Minimum inter-frame gap is therefore 1 CLK cycle.
- A new request raised in the first busy=0 cycle is accepted on that cycle's edge.
- P=1: every bit lasts one cycle, with no extra cycles between bits.
- Prescale changing mid-frame has no effect; the latched value is used.

## Test plan
- Even parity, one cycle per bit. Stimulus: P=1, parity_enable=1, parity_type=0, P_DATA=8'hA5, one-cycle Data_Valid.
  - Required TX_OUT per cycle: 0,1,0,1,0,0,1,0,1,0,1.
  - busy high for exactly 11 cycles, then TX_OUT=1 and busy=0.
- No parity, 8 cycles per bit. Stimulus: P=8, parity_enable=0, P_DATA=8'h0F.
  - Required: each bit held 8 cycles in the order 0,1,1,1,1,0,0,0,0,1.
  - busy high 80 cycles.
- Odd parity. Stimulus: P=4, parity_type=1, P_DATA=8'h01 → parity bit 0. P_DATA=8'h03 → parity bit 1. Each parity bit held 4 cycles.
- Ignored request and input changes while busy. Stimulus: send 8'h55 at P=2; pulse Data_Valid with 8'hFF mid-frame; change Prescale and P_DATA mid-frame.
  - Required: the frame for 8'h55 completes unchanged.
  - No second frame is sent.
- Reset mid-frame and back-to-back frames.
  - Stimulus: assert RST during DATA. Required: TX_OUT=1 and busy=0 asynchronously. After release, a new frame for 8'h3C is correct.
  - Stimulus: hold Data_Valid high continuously. Required: consecutive frames separated by exactly 1 idle cycle.
- Prescale=0. Stimulus: P_DATA=8'hA5, Prescale=0. Required: identical behaviour to Prescale=1, an 11-cycle frame with parity enabled.
